// File: rtl/coriolis_ker0_ostream_sink_pkg.sv
// Shared TyTra definitions for the output-stream sink: FloPoCo exception codes,
// the canonical NaN word, sink FSM states and the FloPoCo-to-IEEE mapping.
package coriolis_ker0_ostream_sink_pkg;

    typedef enum logic [1:0] {
        EXC_ZERO = 2'b00,
        EXC_NORM = 2'b01,
        EXC_INF  = 2'b10,
        EXC_NAN  = 2'b11
    } exc_e;

    localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_DRAIN = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    // body holds the 32-bit sign/exponent/mantissa field; only the sign survives
    // for zero and infinity.
    function automatic logic [31:0] flopoco_to_ieee(input logic [1:0] exc,
                                                    input logic [31:0] body);
        logic [31:0] res;
        case (exc_e'(exc))
            EXC_ZERO: res = {body[31], 31'b0};
            EXC_NORM: res = body;
            EXC_INF:  res = {body[31], 8'hFF, 23'b0};
            default:  res = CANON_NAN;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/coriolis_ker0_ostream_sink_fifo.sv
// Synchronous FIFO with first-word-fall-through head; pointers wrap modulo DEPTH
// and a separate occupancy count tells full from empty.
module tytra_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      occ;
    logic             do_push;
    logic             do_pop;

    assign empty   = (occ == '0);
    assign full    = (occ == (AW+1)'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    // Head reads as zero when empty so the unreset RAM never leaks out.
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/coriolis_ker0_ostream_sink.sv
// Kernel output-stream sink: accepts NELEM FloPoCo words, converts them to IEEE-754
// singles on the way into a FIFO and streams them downstream with valid/ready.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | after reset, waiting for start
// ST_RUN   | accepting upstream elements until NELEM have arrived
// ST_DRAIN | all elements accepted, emptying the FIFO downstream
// ST_DONE  | run complete, done held high, waiting for the next start
module coriolis_ker0_ostream_sink
    import coriolis_ker0_ostream_sink_pkg::*;
#(
    parameter int          STREAMW = 34,
    parameter int          DEPTH   = 4,
    parameter logic [31:0] NELEM   = 32'd1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               ivalid,
    input  logic [STREAMW-1:0] in1_s0,
    output logic               iready,
    output logic               ovalid,
    output logic [31:0]        out1,
    input  logic               oready,
    output logic               done,
    output logic [31:0]        count
);
    state_e      state;
    state_e      state_nxt;
    logic        accept;
    logic        pop;
    logic        fifo_empty;
    logic        fifo_full;
    logic        start_ok;
    logic [31:0] conv;

    assign start_ok = start && (state == ST_IDLE || state == ST_DONE);
    // Built only from registered state so upstream can gate ivalid on it.
    assign iready   = (state == ST_RUN) && !fifo_full && (count != NELEM);
    assign accept   = ivalid && iready;
    assign ovalid   = !fifo_empty;
    assign pop      = ovalid && oready;
    assign conv     = flopoco_to_ieee(in1_s0[STREAMW-1:STREAMW-2], in1_s0[31:0]);

    tytra_sync_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .wdata (conv),
        .pop   (pop),
        .rdata (out1),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start_ok) state_nxt = ST_RUN;
            ST_RUN:   if (accept && count == NELEM - 32'd1) state_nxt = ST_DRAIN;
            ST_DRAIN: if (fifo_empty) state_nxt = ST_DONE;
            ST_DONE:  if (start_ok) state_nxt = ST_RUN;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            count <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start_ok) begin
                count <= '0;
                done  <= 1'b0;
            end else begin
                if (accept) count <= count + 32'd1;
                if (state == ST_DRAIN && state_nxt == ST_DONE) done <= 1'b1;
            end
        end
    end

endmodule
